// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit addSub datapath and the sequencers that drive it.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic cout;
        logic v;
        logic z;
        logic n;
    } flags_t;

    // in_sub value that selects B inversion (subtraction as A + ~B + 1)
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry-out and signed overflow.
module addSub #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             d,
    input  logic             cin,
    input  logic             si,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             v
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff     = d ? ~b : b;
    assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    // Signed overflow: operands agree in sign but the sum does not.
    assign v         = si & (a[WIDTH-1] == b_eff[WIDTH-1]) & (s[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_multiword_seq.sv
// Sequences one NWORDS-wide add/sub through a single-word addSub, LSW first,
// chaining carry word to word, and presents the result on a valid/ready port.
module addsub_multiword_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int NWORDS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*NWORDS-1:0] in_a,
    input  logic [WIDTH*NWORDS-1:0] in_b,
    input  logic                    in_sub,
    input  logic                    in_signed,
    input  logic                    in_cin,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    output logic                    add_d,
    output logic                    add_cin,
    output logic                    add_si,
    input  logic [WIDTH-1:0]        add_s,
    input  logic                    add_cout,
    input  logic                    add_v,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*NWORDS-1:0] out_s,
    output logic                    out_cout,
    output logic                    out_v,
    output logic                    out_z,
    output logic                    out_n
);

    localparam int CW = $clog2(NWORDS);
    localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS - 1);

    typedef logic [NWORDS-1:0][WIDTH-1:0] words_t;

    state_t          state;
    words_t          a_reg;
    words_t          b_reg;
    words_t          res;
    logic            signed_reg;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic            zacc;
    flags_t          flags;

    logic            accept;
    logic            last;
    logic            word_zero;

    // A finished result can be replaced in the same cycle it is taken.
    assign in_ready  = (state == IDLE) | ((state == HOLD) & out_ready);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == LAST_WORD);
    assign word_zero = ~|add_s;

    // Outside RUN these simply hold the last latched values, so they do not toggle.
    assign add_a   = a_reg[cnt];
    assign add_b   = b_reg[cnt];
    assign add_cin = carry;
    assign add_si  = signed_reg & last;
    assign add_d   = 1'b0;

    assign out_valid = (state == HOLD);
    assign out_s     = res;
    assign out_cout  = flags.cout;
    assign out_v     = flags.v;
    assign out_z     = flags.z;
    assign out_n     = flags.n;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            res        <= '0;
            signed_reg <= 1'b0;
            cnt        <= '0;
            carry      <= 1'b0;
            zacc       <= 1'b0;
            flags      <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        a_reg      <= in_a;
                        b_reg      <= (in_sub == OP_SUB) ? ~in_b : in_b;
                        signed_reg <= in_signed;
                        carry      <= (in_sub == OP_SUB) ? 1'b1 : in_cin;
                        cnt        <= '0;
                        zacc       <= 1'b1;
                        state      <= RUN;
                    end else if ((state == HOLD) && out_ready) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res[cnt] <= add_s;
                    carry    <= add_cout;
                    zacc     <= zacc & word_zero;
                    if (last) begin
                        flags <= '{cout: add_cout,
                                   v:    signed_reg & add_v,
                                   z:    zacc & word_zero,
                                   n:    add_s[WIDTH-1]};
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_multiword_seq.sv
// Directed bench: sequencer wired to addSub, 2 x 32-bit words per operation.
module tb_addsub_multiword_seq;

    localparam int WIDTH  = 32;
    localparam int NWORDS = 2;
    localparam int OW     = WIDTH * NWORDS;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [OW-1:0]    in_a;
    logic [OW-1:0]    in_b;
    logic             in_sub;
    logic             in_signed;
    logic             in_cin;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_d;
    logic             add_cin;
    logic             add_si;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;
    logic             add_v;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_s;
    logic             out_cout;
    logic             out_v;
    logic             out_z;
    logic             out_n;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    addsub_multiword_seq #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_signed(in_signed), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_d(add_d), .add_cin(add_cin), .add_si(add_si),
        .add_s(add_s), .add_cout(add_cout), .add_v(add_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_cout(out_cout), .out_v(out_v), .out_z(out_z), .out_n(out_n)
    );

    addSub #(.WIDTH(WIDTH)) alu (
        .a(add_a), .b(add_b), .d(add_d), .cin(add_cin), .si(add_si),
        .s(add_s), .cout(add_cout), .v(add_v)
    );

    // Present an op at a negedge and hold it until the posedge that accepts it.
    task automatic issue(input logic [OW-1:0] a, input logic [OW-1:0] b,
                         input logic sub, input logic sgn, input logic cin);
        bit ok = 1'b0;
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_signed = sgn; in_cin = cin;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid rises (sampled #1 after each edge).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) begin
            n_checks++;
            $display("FAIL done_timeout: out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [OW-1:0] exp_s,
                                input logic [3:0] exp_f);
        n_checks++;
        if (out_s !== exp_s)
            $display("FAIL %s_s: got %h required %h", name, out_s, exp_s);
        else n_pass++;
        n_checks++;
        if ({out_cout, out_v, out_z, out_n} !== exp_f)
            $display("FAIL %s_flags(cvzn): got %b required %b", name,
                     {out_cout, out_v, out_z, out_n}, exp_f);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset_handshake: got %b required 10", {in_ready, out_valid});
        else n_pass++;
        check_result("reset", '0, 4'b0000);
    endtask

    task automatic test_unsigned_add();
        int lat;
        issue(64'h00000000_FFFFFFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        wait_done(lat);
        n_checks++;
        if (lat != NWORDS) $display("FAIL add_latency: got %0d required %0d", lat, NWORDS);
        else n_pass++;
        check_result("add_carry_chain", 64'h00000001_00000000, 4'b0000);
        pop();
    endtask

    task automatic test_unsigned_sub();
        int lat;
        issue(64'h0, 64'hF, 1'b1, 1'b0, 1'b1);
        wait_done(lat);
        check_result("sub_borrow", 64'hFFFFFFFF_FFFFFFF1, 4'b0001);
        pop();
        issue(64'h5, 64'h3, 1'b1, 1'b0, 1'b0);
        wait_done(lat);
        check_result("sub_noborrow", 64'h2, 4'b1000);
        pop();
    endtask

    task automatic test_signed();
        int lat;
        issue(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b1, 1'b0);
        wait_done(lat);
        check_result("signed_add_ovf", 64'h80000000_00000000, 4'b0101);
        pop();
        issue(64'hFFFFFFFF_FFFFFFFF, 64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1, 1'b0);
        wait_done(lat);
        check_result("signed_sub_min", 64'h80000000_00000000, 4'b1001);
        pop();
        // Same overflowing add but unsigned: V must be suppressed.
        issue(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        wait_done(lat);
        check_result("unsigned_no_v", 64'h80000000_00000000, 4'b0001);
        pop();
    endtask

    task automatic test_edges();
        int lat;
        issue('1, '1, 1'b0, 1'b0, 1'b1);
        wait_done(lat);
        check_result("ones_cin", '1, 4'b1001);
        pop();
        issue('0, '0, 1'b0, 1'b0, 1'b0);
        wait_done(lat);
        check_result("zero", '0, 4'b0010);
        pop();
        // Only the upper word is non-zero: Z must look at every word.
        issue(64'h00000001_00000000, 64'h0, 1'b0, 1'b0, 1'b0);
        wait_done(lat);
        check_result("msw_only", 64'h00000001_00000000, 4'b0000);
        pop();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(64'h12345678_9ABCDEF0, 64'h11111111_11111111, 1'b0, 1'b0, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({out_valid, in_ready} !== 2'b10 || out_s !== 64'h23456789_ABCDF001)
                $display("FAIL hold_cycle%0d: valid/ready=%b s=%h required 10 %h",
                         i, {out_valid, in_ready}, out_s, 64'h23456789_ABCDF001);
            else n_pass++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_a = 64'h10; in_b = 64'h20; in_sub = 1'b1; in_signed = 1'b1; in_cin = 1'b0;
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b required 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_valid_drop: got %b required 0", out_valid);
        else n_pass++;
        wait_done(lat);
        n_checks++;
        if (lat != NWORDS) $display("FAIL b2b_latency: got %0d required %0d", lat, NWORDS);
        else n_pass++;
        check_result("b2b_second", 64'hFFFFFFFF_FFFFFFF0, 4'b0001);
        pop();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        issue(64'h00000003_00000007, 64'h00000001_00000001, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL midrun_reset_handshake: got %b required 10", {in_ready, out_valid});
        else n_pass++;
        check_result("midrun_reset", '0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL abandoned_op_output: got %b required 0", out_valid);
        else n_pass++;
        issue(64'h00000003_00000007, 64'h00000001_00000001, 1'b0, 1'b0, 1'b0);
        wait_done(lat);
        check_result("after_reset", 64'h00000004_00000008, 4'b0000);
        pop();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        in_sub = 1'b0; in_signed = 1'b0; in_cin = 1'b0;
        out_ready = 1'b0;
        test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_unsigned_add();
        test_unsigned_sub();
        test_signed();
        test_edges();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/addsub_multiword_seq.md
Name: addsub_multiword_seq

Overview:
- Sequencer upstream of the combinational 32-bit `addSub` unit.
- Accepts one NWORDS×32-bit add/sub operation over a valid/ready handshake.
- Issues it to `addSub` one 32-bit word per cycle, LSW first, chaining Cout into Cin.
- Collects the words into a registered multi-word result with flags, presented on a valid/ready output.

Parameters:
- WIDTH, 32, word width of the attached `addSub`.
- NWORDS, 2, number of words per operation (≥2); operand width = WIDTH*NWORDS.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  sequencer can accept an operation
- in_a  in  WIDTH*NWORDS  operand A
- in_b  in  WIDTH*NWORDS  operand B
- in_sub  in  1  0 = A+B+in_cin, 1 = A−B
- in_signed  in  1  two's-complement operands (selects overflow reporting)
- in_cin  in  1  carry-in for add; ignored for sub
- add_a  out  WIDTH  word to `addSub` A
- add_b  out  WIDTH  word to `addSub` B (already inverted for sub)
- add_d  out  1  always 0 (sequencer performs subtraction by inversion)
- add_cin  out  1  carry into current word
- add_si  out  1  `addSub` Si
- add_s  in  WIDTH  `addSub` sum
- add_cout  in  1  `addSub` carry-out
- add_v  in  1  `addSub` signed overflow
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_s  out  WIDTH*NWORDS  result
- out_cout  out  1  carry out of MSW (sub: 1 = no borrow)
- out_v  out  1  signed overflow
- out_z  out  1  result all zeros
- out_n  out  1  result MSB

Behaviour:
- Reset (async, immediate): state=IDLE; in_ready=1; out_valid=0; out_s=0; out_cout/out_v/out_z/out_n=0; word counter=0; carry reg=0. Reset mid-RUN abandons the operation; no output is produced.
- States: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: latch A, B, sub, signed.
  - Latch B as ~in_b if sub, else in_b.
  - Carry reg = sub ? 1 : in_cin.
  - Counter=0; Z accumulator=1; go to RUN.
- RUN:
  - in_ready=0.
  - Combinational drive: add_a/add_b = word[counter] of latched operands; add_cin = carry reg; add_d=0.
  - add_si = latched signed when counter==NWORDS−1, else 0.
  - Each edge: result word[counter] ← add_s; carry reg ← add_cout; Z acc ← Z acc & (add_s==0).
  - On the last word (counter==NWORDS−1), additionally: out_cout ← add_cout; out_v ← signed ? add_v : 0; out_n ← add_s[WIDTH−1]; go to HOLD.
  - Otherwise counter+1.
  - Latency: NWORDS cycles from accept edge to out_valid=1.
- HOLD:
  - out_valid=1; outputs stable until out_ready.
  - in_ready = out_ready, so an operation can be accepted in the same cycle the result is taken.
  - out_ready & in_valid: latch new op, go to RUN, out_valid falls next cycle.
  - out_ready & !in_valid: go to IDLE.
  - !out_ready: hold; in_ready=0.
- add_a/add_b/add_cin/add_si are don't-care outside RUN; drive them from the latched registers so they do not toggle.
- Throughput: one operation per NWORDS+1 cycles when the consumer is always ready.
- Wrap-around:
  - All-ones + all-ones: out_s = all-ones<<1, out_cout=1.
  - Sub with A<B (unsigned): two's-complement wrap result, out_cout=0.
- out_z = 1 only when every word is zero.
- out_v is the MSW `addSub` V with Si=1; it is 0 for unsigned operations.

Decomposition:
- Shared package `alu_pkg`:
  - WIDTH constant.
  - State enum (IDLE/RUN/HOLD).
  - Flag bundle typedef {cout, v, z, n}.
  - Helper constant for the operand-inversion select.
- No sub-module is required inside the block.
- The `addSub` instance lives at the parent level alongside this block. The bench instantiates both, wired together.

Test Plan:
1. Unsigned add, NWORDS=2: A=0x00000000_FFFFFFFF, B=0x1, cin=0 → out_s=0x00000001_00000000, cout=0, z=0, out_valid 2 cycles after accept.
2. Unsigned sub: A=0x0, B=0xF → out_s=0xFFFFFFFF_FFFFFFF1, cout=0, n=1, v=0. Then A=5, B=3 → out_s=2, cout=1.
3. Signed overflow:
   - A=0x7FFFFFFF_FFFFFFFF, B=0x1, add, signed → out_s=0x80000000_00000000, v=1, n=1.
   - A=0xFFFFFFFF_FFFFFFFF, B=0x7FFFFFFF_FFFFFFFF, sub, signed → out_s=0x80000000_00000000, v=0.
4. Edge add with carry-in: A=B=all-ones, cin=1 → out_s=all-ones, cout=1. Then A=B=0, cin=0 → out_s=0, z=1.
5. Backpressure and back-to-back:
   - out_ready=0 for 5 cycles → out_valid and out_s held, in_ready=0.
   - Assert out_ready with in_valid → new op accepted same cycle; second result correct.
6. Reset mid-RUN: assert rst on the second RUN cycle → out_valid=0, in_ready=1 immediately, all outputs 0. After release, the next op completes correctly.
